csr_access_unit: RTL and testbench

Initiator side of the CSR register file interface. Accepts one Zicsr instruction at a time (CSRRW/CSRRS/CSRRC, register or immediate source) from the execute stage. Sequences a read of the target CSR, computes the new value, then issues the write-back. Returns the old CSR value (the rd result) through a valid/ready response handshake. Sits between the execute stage and the CSR register file; drives that file's read/write select, enable and data ports.

---
 rtl/csr_access_unit_pkg.sv | 33 +++
 rtl/csr_access_unit_alu.sv | 23 ++
 rtl/csr_access_unit.sv | 108 ++++++++++
 tb/tb_csr_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared encodings for the CSR access unit: Zicsr op codes, FSM states and
// the floating-point CSR addresses whose read value is narrowed.
package csr_access_pkg;

    localparam logic [1:0] CSR_OP_ILL = 2'b00;
    localparam logic [1:0] CSR_OP_RW  = 2'b01;
    localparam logic [1:0] CSR_OP_RS  = 2'b10;
    localparam logic [1:0] CSR_OP_RC  = 2'b11;

    typedef logic [1:0] csr_state_t;
    localparam csr_state_t ST_IDLE  = 2'd0;
    localparam csr_state_t ST_READ  = 2'd1;
    localparam csr_state_t ST_WRITE = 2'd2;
    localparam csr_state_t ST_RESP  = 2'd3;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    localparam logic [31:0] FFLAGS_MASK = 32'h0000_001F;
    localparam logic [31:0] FRM_MASK    = 32'h0000_0007;

    // fflags and frm are views of fcsr, so their reads expose only their own field.
    function automatic logic [31:0] read_mask(input logic [11:0] addr);
        case (addr)
            CSR_FFLAGS: return FFLAGS_MASK;
            CSR_FRM:    return FRM_MASK;
            CSR_FCSR:   return '1;
            default:    return '1;
        endcase
    endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational new-value computation for CSRRW / CSRRS / CSRRC.
module csr_alu
    import csr_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    output logic [XLEN-1:0] new_o
);

    always_comb begin
        new_o = old_i;
        case (op_i)
            CSR_OP_RW: new_o = src_i;
            CSR_OP_RS: new_o = old_i | src_i;
            CSR_OP_RC: new_o = old_i & ~src_i;
            default:   new_o = old_i;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: read target CSR, compute new value, write it back, then
// return the old value through a valid/ready response.
module csr_access_unit
    import csr_access_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int XLEN           = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [CSR_ADDR_WIDTH-1:0] req_csr,
    input  logic [XLEN-1:0]           req_src,
    input  logic                      req_src_zero,
    input  logic                      req_rd_zero,
    output logic                      out_read_csr_enable,
    output logic [CSR_ADDR_WIDTH-1:0] out_read_csr_select,
    input  logic [XLEN-1:0]           in_read_csr_data,
    output logic                      out_write_csr_enable,
    output logic [CSR_ADDR_WIDTH-1:0] out_write_csr_select,
    output logic [XLEN-1:0]           out_write_csr_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [XLEN-1:0]           rsp_data,
    output logic                      rsp_illegal
);

    csr_state_t                state_q, state_d;
    logic [1:0]                op_q;
    logic [CSR_ADDR_WIDTH-1:0] csr_q;
    logic [XLEN-1:0]           src_q;
    logic                      src_zero_q;
    logic                      rd_zero_q;
    logic [XLEN-1:0]           old_q;
    logic [XLEN-1:0]           rsp_data_q;
    logic                      rsp_illegal_q;
    logic [XLEN-1:0]           new_val;
    logic                      read_en;
    logic                      do_write;
    logic                      illegal;

    // CSRRW to x0 must not read (side-effecting reads), but still burns the cycle.
    assign read_en  = (state_q == ST_READ) && !((op_q == CSR_OP_RW) && rd_zero_q);
    assign do_write = (op_q == CSR_OP_RW) || !src_zero_q;
    assign illegal  = (op_q == CSR_OP_ILL) ||
                      (do_write && (csr_q[CSR_ADDR_WIDTH-1 -: 2] == 2'b11));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            old_q         <= '0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_READ) begin
                old_q <= read_en ? (in_read_csr_data & XLEN'(read_mask(12'(csr_q)))) : '0;
            end
            if (state_q == ST_WRITE) begin
                rsp_data_q    <= illegal ? '0 : old_q;
                rsp_illegal_q <= illegal;
            end
        end
    end

    // Request fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge CLK) begin
        if (req_valid && req_ready) begin
            op_q       <= req_op;
            csr_q      <= req_csr;
            src_q      <= req_src;
            src_zero_q <= req_src_zero;
            rd_zero_q  <= req_rd_zero;
        end
    end

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op_i  (op_q),
        .old_i (old_q),
        .src_i (src_q),
        .new_o (new_val)
    );

    assign req_ready            = (state_q == ST_IDLE);
    assign out_read_csr_enable  = read_en;
    assign out_read_csr_select  = (state_q == ST_READ) ? csr_q : '0;
    // RESET gates the strobe combinationally so an abort mid-WRITE never lands.
    assign out_write_csr_enable = (state_q == ST_WRITE) && do_write && !illegal && RESET;
    assign out_write_csr_select = (state_q == ST_WRITE) ? csr_q : '0;
    assign out_write_csr_data   = (state_q == ST_WRITE) ? new_val : '0;
    assign rsp_valid            = (state_q == ST_RESP);
    assign rsp_data             = rsp_data_q;
    assign rsp_illegal          = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed vector table, backpressure and reset
// sequences, then random transactions against a behavioural model.
module tb_csr_access_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [11:0] req_csr = '0;
    logic [31:0] req_src = '0;
    logic        req_src_zero = 1'b0;
    logic        req_rd_zero = 1'b0;
    logic        out_read_csr_enable;
    logic [11:0] out_read_csr_select;
    logic [31:0] in_read_csr_data;
    logic        out_write_csr_enable;
    logic [11:0] out_write_csr_select;
    logic [31:0] out_write_csr_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] csrmem [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;

    always #5 CLK = ~CLK;

    csr_access_unit #(.CSR_ADDR_WIDTH(12), .XLEN(32)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_op               (req_op),
        .req_csr              (req_csr),
        .req_src              (req_src),
        .req_src_zero         (req_src_zero),
        .req_rd_zero          (req_rd_zero),
        .out_read_csr_enable  (out_read_csr_enable),
        .out_read_csr_select  (out_read_csr_select),
        .in_read_csr_data     (in_read_csr_data),
        .out_write_csr_enable (out_write_csr_enable),
        .out_write_csr_select (out_write_csr_select),
        .out_write_csr_data   (out_write_csr_data),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_data             (rsp_data),
        .rsp_illegal          (rsp_illegal)
    );

    // CSR register file model: combinational read, write at the clock edge.
    assign in_read_csr_data = csrmem[out_read_csr_select];
    always @(posedge CLK) begin
        if (pre_en) csrmem[pre_addr] <= pre_data;
        else if (out_write_csr_enable) csrmem[out_write_csr_select] <= out_write_csr_data;
    end

    typedef struct {
        logic [1:0]  op;
        logic [11:0] csr;
        logic [31:0] src;
        logic        sz;
        logic        rz;
        logic [31:0] fv;
        logic        e_rd;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic [31:0] e_rsp;
        logic        e_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [11:0] csr, input logic [31:0] src,
                                input logic sz, input logic rz, input logic [31:0] fv,
                                input logic e_rd, input logic e_wen, input logic [31:0] e_wdata,
                                input logic [31:0] e_rsp, input logic e_ill);
        vec_t v;
        v.op = op; v.csr = csr; v.src = src; v.sz = sz; v.rz = rz; v.fv = fv;
        v.e_rd = e_rd; v.e_wen = e_wen; v.e_wdata = e_wdata; v.e_rsp = e_rsp; v.e_ill = e_ill;
        return v;
    endfunction

    // Reference: what an in-order Zicsr instruction observes and leaves behind.
    function automatic vec_t model(input logic [1:0] op, input logic [11:0] csr, input logic [31:0] src,
                                   input logic sz, input logic rz, input logic [31:0] fv);
        vec_t v;
        logic [31:0] old;
        logic wants_write, ill;
        v = mk(op, csr, src, sz, rz, fv, 1'b0, 1'b0, '0, '0, 1'b0);
        if (csr == 12'h001)      old = fv % 32;
        else if (csr == 12'h002) old = fv % 8;
        else                     old = fv;
        v.e_rd = !(op == 2'd1 && rz);
        if (!v.e_rd) old = 0;
        wants_write = (op == 2'd1) || !sz;
        ill = (op == 2'd0) || (wants_write && csr >= 12'hC00);
        case (op)
            2'd1:    v.e_wdata = src;
            2'd2:    v.e_wdata = old | src;
            2'd3:    v.e_wdata = old & ~src;
            default: v.e_wdata = old;
        endcase
        v.e_wen = wants_write && !ill;
        v.e_rsp = ill ? 32'd0 : old;
        v.e_ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge CLK);
        pre_en = 1'b0;
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1; req_op = v.op; req_csr = v.csr; req_src = v.src;
        req_src_zero = v.sz; req_rd_zero = v.rz;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int hold, input string tag);
        logic [31:0] d0;
        logic        i0;
        preload(v.csr, v.fv);
        chk({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
        drive_req(v);
        chk({tag, " rd_en"}, {31'd0, out_read_csr_enable}, {31'd0, v.e_rd});
        if (v.e_rd) chk({tag, " rd_sel"}, {20'd0, out_read_csr_select}, {20'd0, v.csr});
        @(negedge CLK);
        chk({tag, " wr_en"}, {31'd0, out_write_csr_enable}, {31'd0, v.e_wen});
        if (v.e_wen) begin
            chk({tag, " wr_sel"}, {20'd0, out_write_csr_select}, {20'd0, v.csr});
            chk({tag, " wr_data"}, out_write_csr_data, v.e_wdata);
        end
        @(negedge CLK);
        chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " rsp_data"}, rsp_data, v.e_rsp);
        chk({tag, " rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, v.e_ill});
        d0 = rsp_data; i0 = rsp_illegal;
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            chk({tag, " hold valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, " hold data"}, rsp_data, d0);
            chk({tag, " hold illegal"}, {31'd0, rsp_illegal}, {31'd0, i0});
            chk({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk({tag, " post rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, " post req_ready"}, {31'd0, req_ready}, 32'd1);
        if (v.e_wen) chk({tag, " file value"}, csrmem[v.csr], v.e_wdata);
        else         chk({tag, " file kept"}, csrmem[v.csr], v.fv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] csr_pool [0:6];
        vec_t v;
        csr_pool[0] = 12'h001; csr_pool[1] = 12'h002; csr_pool[2] = 12'h003;
        csr_pool[3] = 12'h340; csr_pool[4] = 12'hC00; csr_pool[5] = 12'hC01;
        csr_pool[6] = 12'h7C0;

        //            op    csr      src           sz    rz    fv            rd    wen   wdata         rsp           ill
        vecs.push_back(mk(2'd1, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0));
        vecs.push_back(mk(2'd2, 12'h003, 32'h0000001F, 1'b0, 1'b0, 32'h000000A0, 1'b1, 1'b1, 32'h000000BF, 32'h000000A0, 1'b0));
        vecs.push_back(mk(2'd2, 12'h003, 32'h00000000, 1'b1, 1'b0, 32'h000000A0, 1'b1, 1'b0, 32'h0,        32'h000000A0, 1'b0));
        vecs.push_back(mk(2'd3, 12'h001, 32'h00000003, 1'b0, 1'b0, 32'h000000FF, 1'b1, 1'b1, 32'h0000001C, 32'h0000001F, 1'b0));
        vecs.push_back(mk(2'd1, 12'hC00, 32'h00000005, 1'b0, 1'b0, 32'h00000055, 1'b1, 1'b0, 32'h0,        32'h00000000, 1'b1));
        vecs.push_back(mk(2'd2, 12'hC00, 32'h00000000, 1'b1, 1'b0, 32'h00000055, 1'b1, 1'b0, 32'h0,        32'h00000055, 1'b0));
        vecs.push_back(mk(2'd0, 12'h340, 32'h00000007, 1'b0, 1'b0, 32'h00000099, 1'b1, 1'b0, 32'h0,        32'h00000000, 1'b1));
        vecs.push_back(mk(2'd1, 12'h340, 32'h00000011, 1'b0, 1'b1, 32'h00002222, 1'b0, 1'b1, 32'h00000011, 32'h00000000, 1'b0));
        vecs.push_back(mk(2'd3, 12'h002, 32'h00000001, 1'b0, 1'b0, 32'h000000FF, 1'b1, 1'b1, 32'h00000006, 32'h00000007, 1'b0));
        vecs.push_back(mk(2'd2, 12'hC01, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0,        32'h00000000, 1'b1));
        vecs.push_back(mk(2'd2, 12'h001, 32'h0000FF00, 1'b0, 1'b0, 32'h0000FFFF, 1'b1, 1'b1, 32'h0000FF1F, 32'h0000001F, 1'b0));

        // Reset state
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        chk("reset wr_en", {31'd0, out_write_csr_enable}, 32'd0);
        chk("reset rd_en", {31'd0, out_read_csr_enable}, 32'd0);

        // Directed table
        foreach (vecs[i]) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

        // Backpressure, then the next request must be accepted
        run_vec(vecs[0], 5, "bp");
        run_vec(vecs[3], 0, "after_bp");

        // Reset asserted during WRITE: no strobe, no response, file untouched
        preload(12'h340, 32'hAAAA5555);
        drive_req(mk(2'd1, 12'h340, 32'h00001234, 1'b0, 1'b0, 32'hAAAA5555, 1'b1, 1'b1, 32'h1234, 32'hAAAA5555, 1'b0));
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_mid wr_en", {31'd0, out_write_csr_enable}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_mid req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid rsp_data", rsp_data, 32'd0);
        chk("rst_mid file", csrmem[12'h340], 32'hAAAA5555);
        @(negedge CLK);
        chk("rst_mid idle rsp_valid", {31'd0, rsp_valid}, 32'd0);
        run_vec(vecs[1], 0, "after_rst");

        // Random transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [11:0] csr;
            logic [31:0] src;
            logic        rz;
            op  = 2'($urandom_range(0, 3));
            csr = csr_pool[$urandom_range(0, 6)];
            src = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rz  = 1'($urandom_range(0, 1));
            v = model(op, csr, src, (src == 32'd0), rz, $urandom);
            run_vec(v, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
